// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin request/grant front end that shares one multdiv unit between two
// requesters, registers the winning operation and buffers the result for its owner.

package ibex_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;
endpackage

module ibex_multdiv_arbiter
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  md_op_e      operator_i    [2],
  input  logic [1:0]  signed_mode_i [2],
  input  logic [31:0] op_a_i        [2],
  input  logic [31:0] op_b_i        [2],
  output logic [1:0]  gnt_o,
  output logic [1:0]  rvalid_o,
  output logic [31:0] rdata_o,
  input  logic [1:0]  rready_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic        md_mult_sel_o,
  output logic        md_div_sel_o,
  output md_op_e      md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  output logic        md_ready_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        arm_q, arm_d;
  md_op_e      op_q, op_d;
  logic [1:0]  sm_q, sm_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        mult_q, mult_d;
  logic        div_q, div_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic        win;
  logic [1:0]  gnt;
  logic        win_is_mult;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    win = rr_ptr_q;
    if (req_i == 2'b01) begin
      win = 1'b0;
    end else if (req_i == 2'b10) begin
      win = 1'b1;
    end
    gnt = 2'b00;
    if (state_q == IDLE && arm_q && req_i != 2'b00) begin
      gnt = win ? 2'b10 : 2'b01;
    end
    win_is_mult = (operator_i[win] == MD_OP_MULL) || (operator_i[win] == MD_OP_MULH);
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    arm_d    = 1'b1;
    op_d     = op_q;
    sm_d     = sm_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mult_d   = mult_q;
    div_d    = div_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    rvalid_d = rvalid_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d  = BUSY;
          owner_d  = win;
          rr_ptr_d = ~win;
          op_d     = operator_i[win];
          sm_d     = signed_mode_i[win];
          a_d      = op_a_i[win];
          b_d      = op_b_i[win];
          mult_d   = win_is_mult;
          div_d    = ~win_is_mult;
          ready_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      BUSY: begin
        if (md_valid_i) begin
          state_d  = RESP;
          result_d = md_result_i;
          mult_d   = 1'b0;
          div_d    = 1'b0;
          ready_d  = 1'b0;
          rvalid_d = owner_q ? 2'b10 : 2'b01;
        end
      end
      RESP: begin
        if (rready_i[owner_q]) begin
          state_d  = IDLE;
          rvalid_d = 2'b00;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        mult_d   = 1'b0;
        div_d    = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        rvalid_d = 2'b00;
      end
    endcase
  end

  // arm_q keeps grants off for the first cycle after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      arm_q    <= 1'b0;
      op_q     <= MD_OP_MULL;
      sm_q     <= 2'b00;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      arm_q    <= arm_d;
      op_q     <= op_d;
      sm_q     <= sm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Outputs are forced low while reset is held, whatever state the flops are in.
  assign gnt_o            = rst_i ? 2'b00 : gnt;
  assign rvalid_o         = rst_i ? 2'b00 : rvalid_q;
  assign rdata_o          = rst_i ? 32'd0 : result_q;
  assign md_mult_en_o     = ~rst_i & mult_q;
  assign md_mult_sel_o    = ~rst_i & mult_q;
  assign md_div_en_o      = ~rst_i & div_q;
  assign md_div_sel_o     = ~rst_i & div_q;
  assign md_ready_o       = ~rst_i & ready_q;
  assign md_operator_o    = rst_i ? MD_OP_MULL : op_q;
  assign md_signed_mode_o = rst_i ? 2'b00 : sm_q;
  assign md_op_a_o        = rst_i ? 32'd0 : a_q;
  assign md_op_b_o        = rst_i ? 32'd0 : b_q;
  assign busy_o           = ~rst_i & busy_q;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Directed bench for ibex_multdiv_arbiter with a small behavioural multdiv unit
// of fixed 3-cycle latency computing results from the arbiter's registered operation.

module tb_ibex_multdiv_arbiter;
  import ibex_pkg::*;

  logic        clk;
  logic        rst_i;
  logic [1:0]  req_i;
  md_op_e      operator_i    [2];
  logic [1:0]  signed_mode_i [2];
  logic [31:0] op_a_i        [2];
  logic [31:0] op_b_i        [2];
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rready_i;
  logic        md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  md_op_e      md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o, md_op_b_o;
  logic        md_ready_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;
  logic        busy_o;

  int compared   = 0;
  int mismatched = 0;
  int two_hot    = 0;
  int div_cycles = 0;
  int mult_cycles = 0;
  int unit_cnt   = 0;

  ibex_multdiv_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .operator_i       (operator_i),
    .signed_mode_i    (signed_mode_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .gnt_o            (gnt_o),
    .rvalid_o         (rvalid_o),
    .rdata_o          (rdata_o),
    .rready_i         (rready_i),
    .md_mult_en_o     (md_mult_en_o),
    .md_div_en_o      (md_div_en_o),
    .md_mult_sel_o    (md_mult_sel_o),
    .md_div_sel_o     (md_div_sel_o),
    .md_operator_o    (md_operator_o),
    .md_signed_mode_o (md_signed_mode_o),
    .md_op_a_o        (md_op_a_o),
    .md_op_b_o        (md_op_b_o),
    .md_ready_o       (md_ready_o),
    .md_valid_i       (md_valid_i),
    .md_result_i      (md_result_i),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] allOutputs();
    return {18'd0, gnt_o, rvalid_o, rdata_o, md_mult_en_o, md_div_en_o, md_mult_sel_o,
            md_div_sel_o, 2'(md_operator_o), md_signed_mode_o, md_op_a_o, md_op_b_o,
            md_ready_o, busy_o};
  endfunction

  function automatic logic [31:0] unitResult(input md_op_e op, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] sa, sb;
    logic signed [65:0] prod;
    logic signed [31:0] qs;
    sa   = {sm[0] & a[31], a};
    sb   = {sm[1] & b[31], b};
    prod = sa * sb;
    case (op)
      MD_OP_MULL: return prod[31:0];
      MD_OP_MULH: return prod[63:32];
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sm == 2'b11) begin
          qs = $signed(a) / $signed(b);
          return qs;
        end
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sm == 2'b11) begin
          qs = $signed(a) % $signed(b);
          return qs;
        end
        return a % b;
      end
    endcase
  endfunction

  // Behavioural multdiv unit: answers on the third enabled+ready cycle.
  initial begin
    md_valid_i  = 1'b0;
    md_result_i = 32'd0;
    forever begin
      @(negedge clk);
      if (gnt_o == 2'b11) two_hot++;
      if (md_div_en_o) div_cycles++;
      if (md_mult_en_o) mult_cycles++;
      if (!rst_i && (md_mult_en_o || md_div_en_o) && md_ready_o) begin
        unit_cnt++;
        md_valid_i  = (unit_cnt == 3);
        md_result_i = md_valid_i ? unitResult(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o)
                                 : 32'hDEAD_BEEF;
      end else begin
        unit_cnt   = 0;
        md_valid_i = 1'b0;
      end
    end
  end

  task automatic setPort(input int p, input md_op_e op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b);
    operator_i[p]    = op;
    signed_mode_i[p] = sm;
    op_a_i[p]        = a;
    op_b_i[p]        = b;
    req_i[p]         = 1'b1;
  endtask

  task automatic waitGrant(input string tag, input logic [1:0] exp);
    bit got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (gnt_o != 2'b00);
    end
    checkOutput(tag, gnt_o, exp);
  endtask

  task automatic waitResult(input string tag, input int p, input logic [31:0] exp, output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      n++;
      got = (rvalid_o != 2'b00);
    end
    checkOutput({tag, " rvalid"}, rvalid_o, (p == 1) ? 2'b10 : 2'b01);
    checkOutput({tag, " rdata"}, rdata_o, exp);
  endtask

  task automatic acceptResult(input int p);
    rready_i[p] = 1'b1;
    @(posedge clk);
    #1 rready_i[p] = 1'b0;
  endtask

  task automatic dropReq(input int p);
    @(posedge clk);
    #1 req_i[p] = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input int p, input md_op_e op, input logic [1:0] sm,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    @(posedge clk);
    #1 setPort(p, op, sm, a, b);
    waitGrant({tag, " gnt"}, (p == 1) ? 2'b10 : 2'b01);
    dropReq(p);
    waitResult(tag, p, exp, n);
    acceptResult(p);
  endtask

  initial begin
    int n, m0, d0, bad;
    rst_i    = 1'b1;
    req_i    = 2'b00;
    rready_i = 2'b00;
    for (int p = 0; p < 2; p++) setPort(p, MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000);

    $display("[TB] reset with both ports requesting MULH");
    @(negedge clk);
    checkOutput("reset cycle outputs", allOutputs(), 128'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("post-reset outputs", allOutputs(), 128'd0);
    for (int k = 0; k < 4; k++) begin
      waitGrant($sformatf("rr grant %0d", k), (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 3) dropReq(0);
      if (k == 3) req_i = 2'b00;
      waitResult($sformatf("rr op %0d", k), k % 2, 32'h4000_0000, n);
      acceptResult(k % 2);
    end
    checkOutput("grant never two-hot", two_hot, 0);

    $display("[TB] single-port operations");
    m0 = mult_cycles;
    d0 = div_cycles;
    @(posedge clk);
    #1 setPort(0, MD_OP_MULL, 2'b00, 32'd7, 32'd6);
    waitGrant("mull gnt", 2'b01);
    dropReq(0);
    waitResult("mull 7x6", 0, 32'h0000_002A, n);
    checkOutput("mull latency", n, 4);
    acceptResult(0);
    checkOutput("mull enable cycles", mult_cycles - m0, 3);
    checkOutput("mull no div enable", div_cycles - d0, 0);

    applyStimulus("div -7/2", 1, MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    applyStimulus("rem -7%2", 1, MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    applyStimulus("div by 0", 0, MD_OP_DIV, 2'b00, 32'h0000_0055, 32'd0, 32'hFFFF_FFFF);
    applyStimulus("rem by 0", 0, MD_OP_REM, 2'b00, 32'h0000_1234, 32'd0, 32'h0000_1234);

    $display("[TB] stalled response with a waiting foreign request");
    @(posedge clk);
    #1 setPort(0, MD_OP_MULL, 2'b00, 32'd9, 32'd9);
    waitGrant("stall gnt", 2'b01);
    dropReq(0);
    waitResult("stall first", 0, 32'h0000_0051, n);
    setPort(1, MD_OP_DIV, 2'b00, 32'd100, 32'd7);
    rready_i[1] = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rvalid_o != 2'b01 || rdata_o != 32'h51 || gnt_o != 2'b00 ||
          md_mult_en_o || md_div_en_o || md_ready_o) bad++;
    end
    checkOutput("stall held cycles", bad, 0);
    rready_i[1] = 1'b0;
    acceptResult(0);
    @(negedge clk);
    checkOutput("grant after stall", gnt_o, 2'b10);
    dropReq(1);
    waitResult("div 100/7", 1, 32'h0000_000E, n);
    acceptResult(1);

    $display("[TB] reset during a DIV");
    @(posedge clk);
    #1 setPort(0, MD_OP_DIV, 2'b00, 32'd100, 32'd3);
    waitGrant("abort gnt", 2'b01);
    dropReq(0);
    @(negedge clk);
    checkOutput("abort div busy", {md_div_en_o, md_mult_en_o, busy_o}, 3'b101);
    @(posedge clk);
    #1 rst_i = 1'b1;
    setPort(0, MD_OP_MULL, 2'b00, 32'd3, 32'd5);
    setPort(1, MD_OP_MULL, 2'b00, 32'd4, 32'd4);
    @(negedge clk);
    checkOutput("mid-busy reset cycle", allOutputs(), 128'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("after mid-busy reset", allOutputs(), 128'd0);
    waitGrant("post-reset gnt p0", 2'b01);
    dropReq(0);
    waitResult("mull 3x5", 0, 32'h0000_000F, n);
    acceptResult(0);
    waitGrant("post-reset gnt p1", 2'b10);
    dropReq(1);
    waitResult("mull 4x4", 1, 32'h0000_0010, n);
    acceptResult(1);
    checkOutput("grant never two-hot end", two_hot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
